// File: rtl/axi_r_arb_pkg.sv
// axi_r_arb_pkg
//   Shared types and helpers for the AXI read-data channel arbiter and the
//   round-robin arbiter it is built on.
//   - arb_state_t : burst FSM state (IDLE, BURST)
//   - idx_width() : width of an index into n channels, never less than 1
package axi_r_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   // $clog2(1) is 0, which would give a zero-width index for a single
   // channel; clamp to one bit so the index ports always exist.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axi_r_arb_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin pick. Scans the request vector starting
//   at the channel just after last_grant and wrapping modulo N; the first
//   asserted request wins.
//   Ports:
//     req         in  N   request per channel
//     last_grant  in  CL  channel granted most recently
//     grant       out CL  index of the chosen channel (0 when none)
//     grant_valid out 1   at least one request present
module rr_arbiter #(
   parameter int N  = 4,
   parameter int CL = 2
) (
   input  logic [N-1:0]  req,
   input  logic [CL-1:0] last_grant,
   output logic [CL-1:0] grant,
   output logic          grant_valid
);

   always_comb begin
      int idx;
      idx         = 0;
      grant       = '0;
      grant_valid = 1'b0;
      // Offset 1..N visits every channel once, ending on last_grant itself,
      // so a lone requester that was just served can still be granted again.
      for (int k = 1; k <= N; k++) begin
         idx = int'(last_grant) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (!grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant       = CL'(idx);
         end
      end
   end

endmodule

// File: rtl/axi_r_arb.sv
// axi_r_arb
//   Merges M_COUNT upstream AXI R channels into one downstream R channel.
//   Whole bursts are granted in round-robin order; a grant is held until the
//   beat carrying rlast is taken. The downstream side is a single output
//   register, so nothing upstream reaches out_* combinationally.
//   Ports:
//     clk, rst                         clock, asynchronous active-high reset
//     in_rid/rdata/rresp/rlast/ruser   upstream payload, channel i at slice i
//     in_rvalid / in_rready            upstream handshake (rready one-hot or 0)
//     out_rid/rdata/rresp/rlast/ruser  downstream payload (registered)
//     out_rsrc                         channel that sourced the current beat
//     out_rvalid / out_rready          downstream handshake
module axi_r_arb
   import axi_r_arb_pkg::*;
#(
   parameter int M_COUNT     = 4,
   parameter int ID_WIDTH    = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int RUSER_WIDTH = 1,
   parameter int CL_M_COUNT  = idx_width(M_COUNT)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [M_COUNT*ID_WIDTH-1:0]    in_rid,
   input  logic [M_COUNT*DATA_WIDTH-1:0]  in_rdata,
   input  logic [M_COUNT*2-1:0]           in_rresp,
   input  logic [M_COUNT-1:0]             in_rlast,
   input  logic [M_COUNT*RUSER_WIDTH-1:0] in_ruser,
   input  logic [M_COUNT-1:0]             in_rvalid,
   output logic [M_COUNT-1:0]             in_rready,
   output logic [ID_WIDTH-1:0]            out_rid,
   output logic [DATA_WIDTH-1:0]          out_rdata,
   output logic [1:0]                     out_rresp,
   output logic                           out_rlast,
   output logic [RUSER_WIDTH-1:0]         out_ruser,
   output logic [CL_M_COUNT-1:0]          out_rsrc,
   output logic                           out_rvalid,
   input  logic                           out_rready
);

   arb_state_t            state_reg, state_next;
   logic [CL_M_COUNT-1:0] grant_reg, grant_next;
   logic [CL_M_COUNT-1:0] last_grant_reg, last_grant_next;
   logic [CL_M_COUNT-1:0] arb_grant;
   logic                  arb_valid;
   logic                  out_free;
   logic                  load;

   // Per-channel views of the flattened payload buses.
   logic [ID_WIDTH-1:0]    rid_arr   [M_COUNT];
   logic [DATA_WIDTH-1:0]  rdata_arr [M_COUNT];
   logic [1:0]             rresp_arr [M_COUNT];
   logic [RUSER_WIDTH-1:0] ruser_arr [M_COUNT];

   for (genvar gi = 0; gi < M_COUNT; gi++) begin : g_slice
      assign rid_arr[gi]   = in_rid[gi*ID_WIDTH +: ID_WIDTH];
      assign rdata_arr[gi] = in_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign rresp_arr[gi] = in_rresp[gi*2 +: 2];
      assign ruser_arr[gi] = in_ruser[gi*RUSER_WIDTH +: RUSER_WIDTH];
   end

   rr_arbiter #(
      .N  (M_COUNT),
      .CL (CL_M_COUNT)
   ) u_rr_arbiter (
      .req         (in_rvalid),
      .last_grant  (last_grant_reg),
      .grant       (arb_grant),
      .grant_valid (arb_valid)
   );

   // The output register can take a beat when empty or when its current
   // beat leaves this cycle; this is what gives full throughput.
   assign out_free = !out_rvalid || out_rready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         grant_reg      <= '0;
         // Start just "behind" channel 0 so channel 0 wins first.
         last_grant_reg <= CL_M_COUNT'(M_COUNT - 1);
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      in_rready       = '0;
      load            = 1'b0;
      case (state_reg)
         IDLE: begin
            if (arb_valid) begin
               grant_next = arb_grant;
               state_next = BURST;
            end
         end
         BURST: begin
            in_rready[grant_reg] = out_free;
            // A granted channel that drops rvalid simply stalls the burst.
            if (in_rvalid[grant_reg] && out_free) begin
               load = 1'b1;
               if (in_rlast[grant_reg]) begin
                  last_grant_next = grant_reg;
                  state_next      = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_rid    <= '0;
         out_rdata  <= '0;
         out_rresp  <= '0;
         out_rlast  <= 1'b0;
         out_ruser  <= '0;
         out_rsrc   <= '0;
         out_rvalid <= 1'b0;
      end else if (load) begin
         out_rid    <= rid_arr[grant_reg];
         out_rdata  <= rdata_arr[grant_reg];
         out_rresp  <= rresp_arr[grant_reg];
         out_rlast  <= in_rlast[grant_reg];
         out_ruser  <= ruser_arr[grant_reg];
         out_rsrc   <= grant_reg;
         out_rvalid <= 1'b1;
      end else if (out_rready) begin
         out_rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi_r_arb.sv
// tb_axi_r_arb
//   Directed bench: a 4-channel/32-bit arbiter and a 1-channel/128-bit build.
//   Per-channel beat queues feed the inputs; accepted output beats are
//   compared in order against hand-written expected sequences.
module tb_axi_r_arb;

   localparam int M = 4;

   typedef struct packed {
      logic [7:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic        user;
   } beat_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // 4-channel instance
   logic [M*8-1:0]  in_rid;
   logic [M*32-1:0] in_rdata;
   logic [M*2-1:0]  in_rresp;
   logic [M-1:0]    in_rlast, in_ruser, in_rvalid, in_rready;
   logic [7:0]      out_rid;
   logic [31:0]     out_rdata;
   logic [1:0]      out_rresp;
   logic            out_rlast, out_ruser;
   logic [1:0]      out_rsrc;
   logic            out_rvalid, out_rready;

   // 1-channel, 128-bit instance
   logic [7:0]   s_in_rid;
   logic [127:0] s_in_rdata;
   logic [1:0]   s_in_rresp;
   logic         s_in_rlast, s_in_ruser, s_in_rvalid, s_in_rready;
   logic [7:0]   s_out_rid;
   logic [127:0] s_out_rdata;
   logic [1:0]   s_out_rresp;
   logic         s_out_rlast, s_out_ruser, s_out_rsrc, s_out_rvalid, s_out_rready;

   axi_r_arb #(.M_COUNT(M), .ID_WIDTH(8), .DATA_WIDTH(32), .RUSER_WIDTH(1)) dut (
      .clk(clk), .rst(rst),
      .in_rid(in_rid), .in_rdata(in_rdata), .in_rresp(in_rresp), .in_rlast(in_rlast),
      .in_ruser(in_ruser), .in_rvalid(in_rvalid), .in_rready(in_rready),
      .out_rid(out_rid), .out_rdata(out_rdata), .out_rresp(out_rresp), .out_rlast(out_rlast),
      .out_ruser(out_ruser), .out_rsrc(out_rsrc), .out_rvalid(out_rvalid), .out_rready(out_rready)
   );

   axi_r_arb #(.M_COUNT(1), .ID_WIDTH(8), .DATA_WIDTH(128), .RUSER_WIDTH(1)) dut1 (
      .clk(clk), .rst(rst),
      .in_rid(s_in_rid), .in_rdata(s_in_rdata), .in_rresp(s_in_rresp), .in_rlast(s_in_rlast),
      .in_ruser(s_in_ruser), .in_rvalid(s_in_rvalid), .in_rready(s_in_rready),
      .out_rid(s_out_rid), .out_rdata(s_out_rdata), .out_rresp(s_out_rresp), .out_rlast(s_out_rlast),
      .out_ruser(s_out_ruser), .out_rsrc(s_out_rsrc), .out_rvalid(s_out_rvalid), .out_rready(s_out_rready)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   beat_t        srcq [M][$];
   beat_t        expq [$];
   int           exps [$];
   int           acc_cyc [$];
   logic [127:0] q1 [$];
   logic         l1 [$];
   logic [127:0] e1 [$];
   logic         el1 [$];
   int           acc1 [$];

   logic         toggle_rdy = 1'b0;
   logic         stall_prev = 1'b0;
   logic [47:0]  snap;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic beat_t mk(input int ch, input int b, input logic last);
      beat_t r;
      r.id   = 8'(8'h10 + ch);
      r.data = 32'hA000_0000 | 32'(ch << 8) | 32'(b);
      r.resp = 2'(b);
      r.last = last;
      r.user = 1'(b);
      return r;
   endfunction

   task automatic push_burst(input int ch, input int first, input int len);
      for (int b = 0; b < len; b++) srcq[ch].push_back(mk(ch, first + b, (b == len - 1)));
   endtask

   task automatic expect_burst(input int ch, input int first, input int len);
      for (int b = 0; b < len; b++) begin
         expq.push_back(mk(ch, first + b, (b == len - 1)));
         exps.push_back(ch);
      end
   endtask

   task automatic drive();
      beat_t b;
      for (int ch = 0; ch < M; ch++) begin
         if (srcq[ch].size() > 0) begin
            b = srcq[ch][0];
            in_rvalid[ch] = 1'b1;
         end else begin
            b = '0;
            b.data = 32'hDEAD_0000 | 32'(ch);
            in_rvalid[ch] = 1'b0;
         end
         in_rid[ch*8 +: 8]    = b.id;
         in_rdata[ch*32 +: 32] = b.data;
         in_rresp[ch*2 +: 2]  = b.resp;
         in_rlast[ch]         = b.last;
         in_ruser[ch]         = b.user;
      end
      if (q1.size() > 0) begin
         s_in_rvalid = 1'b1;
         s_in_rdata  = q1[0];
         s_in_rlast  = l1[0];
      end else begin
         s_in_rvalid = 1'b0;
         s_in_rdata  = '0;
         s_in_rlast  = 1'b0;
      end
      if (toggle_rdy) out_rready = ~out_rready;
   endtask

   task automatic monitor();
      beat_t e;
      int    s;
      if (stall_prev)
         chk("stall hold", {out_rvalid, out_rid, out_rdata, out_rresp, out_rlast, out_ruser, out_rsrc}, snap);
      chk("rready onehot0", 128'($onehot0(in_rready)), 1);
      if (out_rvalid && out_rready) begin
         if (expq.size() == 0) begin
            chk("extra beat", {out_rvalid, out_rready}, 0);
         end else begin
            e = expq.pop_front();
            s = exps.pop_front();
            chk("beat", {out_rid, out_rdata, out_rresp, out_rlast, out_ruser}, e);
            chk("src", out_rsrc, s);
            acc_cyc.push_back(cyc);
         end
      end
      stall_prev = out_rvalid && !out_rready;
      snap = {out_rvalid, out_rid, out_rdata, out_rresp, out_rlast, out_ruser, out_rsrc};
      if (s_out_rvalid && s_out_rready) begin
         if (e1.size() == 0) begin
            chk("m1 extra beat", {s_out_rvalid, s_out_rready}, 0);
         end else begin
            chk("m1 data", s_out_rdata, e1.pop_front());
            chk("m1 last", s_out_rlast, el1.pop_front());
            chk("m1 src", s_out_rsrc, 0);
            acc1.push_back(cyc);
         end
      end
   endtask

   // One clock: sample handshakes and outputs at negedge, advance sources
   // just after the next posedge.
   task automatic step();
      logic [M-1:0] hs;
      logic         hs1;
      @(negedge clk);
      hs  = in_rvalid & in_rready;
      hs1 = s_in_rvalid & s_in_rready;
      monitor();
      @(posedge clk);
      #1;
      cyc++;
      for (int ch = 0; ch < M; ch++) if (hs[ch]) void'(srcq[ch].pop_front());
      if (hs1) begin
         void'(q1.pop_front());
         void'(l1.pop_front());
      end
      drive();
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while ((expq.size() > 0 || e1.size() > 0) && n < budget) begin
         step();
         n++;
      end
      chk("drain timeout", 128'(expq.size() + e1.size()), 0);
      repeat (3) step();
   endtask

   initial begin
      int c0;
      int n;
      rst = 1'b1;
      out_rready = 1'b1;
      s_out_rready = 1'b1;
      s_in_rid = 8'h5A;
      s_in_rresp = 2'b00;
      s_in_ruser = 1'b0;
      drive();
      repeat (3) @(posedge clk);
      #1;
      chk("rst out_rvalid", out_rvalid, 0);
      chk("rst in_rready", in_rready, 0);
      chk("rst out_rsrc", out_rsrc, 0);
      chk("rst out_rdata", out_rdata, 0);
      chk("rst m1 out_rvalid", s_out_rvalid, 0);
      rst = 1'b0;

      // Channel 0, 4-beat burst: beats accepted on cycles 2..5.
      c0 = cyc;
      acc_cyc.delete();
      push_burst(0, 0, 4);
      expect_burst(0, 0, 4);
      drive();
      wait_done(40);
      chk("t1 count", 128'(acc_cyc.size()), 4);
      chk("t1 first lat", 128'(acc_cyc[0] - c0), 2);
      chk("t1 last lat", 128'(acc_cyc[3] - c0), 5);
      $display("t1 single burst ch0 done, vectors=%0d", n_vec);

      // Channels 1 and 3 together after channel 0: 1 completes, then 3.
      push_burst(3, 0, 2);
      push_burst(1, 0, 3);
      expect_burst(1, 0, 3);
      expect_burst(3, 0, 2);
      drive();
      wait_done(40);
      $display("t2 ch1 then ch3 done, vectors=%0d", n_vec);

      // All four with 1-beat bursts: order 0,1,2,3,0,1,2,3, one beat per 2 cycles.
      acc_cyc.delete();
      for (int ch = 0; ch < M; ch++) begin
         push_burst(ch, 0, 1);
         push_burst(ch, 1, 1);
      end
      for (int r = 0; r < 2; r++)
         for (int ch = 0; ch < M; ch++) expect_burst(ch, r, 1);
      drive();
      wait_done(60);
      chk("t3 count", 128'(acc_cyc.size()), 8);
      for (int i = 0; i < 7; i++) chk("t3 spacing", 128'(acc_cyc[i+1] - acc_cyc[i]), 2);
      $display("t3 round robin done, vectors=%0d", n_vec);

      // Channel 2, 8 beats, out_rready toggling each cycle.
      push_burst(2, 0, 8);
      expect_burst(2, 0, 8);
      toggle_rdy = 1'b1;
      drive();
      wait_done(80);
      toggle_rdy = 1'b0;
      out_rready = 1'b1;
      stall_prev = 1'b0;
      $display("t4 backpressure burst done, vectors=%0d", n_vec);

      // Reset mid-burst on channel 1 after two beats.
      acc_cyc.delete();
      push_burst(1, 0, 6);
      expect_burst(1, 0, 6);
      drive();
      n = 0;
      while (acc_cyc.size() < 2 && n < 20) begin
         step();
         n++;
      end
      chk("t5 two beats seen", 128'(acc_cyc.size()), 2);
      chk("t5 pre-rst valid", out_rvalid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("t5 rst out_rvalid", out_rvalid, 0);
      chk("t5 rst in_rready", in_rready, 0);
      chk("t5 rst out_rsrc", out_rsrc, 0);
      chk("t5 rst out_rdata", out_rdata, 0);
      for (int ch = 0; ch < M; ch++) srcq[ch].delete();
      expq.delete();
      exps.delete();
      stall_prev = 1'b0;
      drive();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      push_burst(2, 0, 1);
      push_burst(0, 0, 1);
      expect_burst(0, 0, 1);
      expect_burst(2, 0, 1);
      drive();
      wait_done(40);
      $display("t5 reset mid-burst done, vectors=%0d", n_vec);

      // Single-channel 128-bit build: bursts of 3 then 2 beats.
      c0 = cyc;
      acc1.delete();
      for (int b = 0; b < 5; b++) begin
         logic [127:0] d;
         d = {4{32'hB000_0000 | 32'(b)}};
         q1.push_back(d);
         l1.push_back(b == 2 || b == 4);
         e1.push_back(d);
         el1.push_back(b == 2 || b == 4);
      end
      drive();
      wait_done(40);
      chk("t6 count", 128'(acc1.size()), 5);
      chk("t6 beat0 lat", 128'(acc1[0] - c0), 2);
      chk("t6 beat2 lat", 128'(acc1[2] - c0), 4);
      chk("t6 beat3 lat", 128'(acc1[3] - c0), 6);
      chk("t6 beat4 lat", 128'(acc1[4] - c0), 7);
      $display("t6 single channel done, vectors=%0d", n_vec);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/axi_r_arb.md
# axi_r_arb

Parametrised AXI read-data (R) channel arbiter that merges M_COUNT upstream R channels into one downstream R channel. Grants whole bursts in round-robin order, holds the grant until the beat carrying `rlast` is accepted, and registers the output for timing closure. Sits on the return path of the interconnect, between the per-slave R channels and a single master port. Generalises the fixed-width per-port R buses to any channel count, ID, data and user width, with burst locking and source tagging.

## Interface
- M_COUNT, 4, number of upstream R channels (>=1)
- ID_WIDTH, 8, rid width
- DATA_WIDTH, 32, rdata width
- RUSER_WIDTH, 1, ruser width
- CL_M_COUNT, $clog2(M_COUNT) (min 1), source index width (derived)

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_rid  in  M_COUNT*ID_WIDTH  upstream rid, channel i at slice i
- in_rdata  in  M_COUNT*DATA_WIDTH  upstream rdata
- in_rresp  in  M_COUNT*2  upstream rresp
- in_rlast  in  M_COUNT  upstream rlast
- in_ruser  in  M_COUNT*RUSER_WIDTH  upstream ruser
- in_rvalid  in  M_COUNT  upstream rvalid
- in_rready  out  M_COUNT  upstream rready, one-hot or zero
- out_rid  out  ID_WIDTH  downstream rid
- out_rdata  out  DATA_WIDTH  downstream rdata
- out_rresp  out  2  downstream rresp
- out_rlast  out  1  downstream rlast
- out_ruser  out  RUSER_WIDTH  downstream ruser
- out_rsrc  out  CL_M_COUNT  index of channel that sourced the current beat
- out_rvalid  out  1  downstream rvalid
- out_rready  in  1  downstream rready

## Operation
- State machine: IDLE, BURST.
- IDLE: all in_rready low. If any in_rvalid high, pick the first requester at index > last_grant (wrapping mod M_COUNT); register grant; go to BURST next cycle. No request -> stay.
- BURST: in_rready[grant] = !out_rvalid || out_rready; all others low. On in_rvalid[grant] && in_rready[grant], load beat (id, data, resp, last, user, src=grant) into the output register. If that beat has rlast=1: last_grant <= grant, go to IDLE.
- Output register: out_rvalid set on load; cleared when out_rready && !load. Load and drain in the same cycle is allowed (full throughput).
- Granted channel dropping rvalid mid-burst: grant held, no beat taken, no timeout.
- Payload of non-granted channels never reaches the output.
- Reset (any time, including mid-burst): state IDLE, last_grant = M_COUNT-1 (channel 0 wins first), out_rvalid=0, in_rready=0, out_rsrc=0, out payload=0. Partial burst is discarded downstream-visibly by out_rvalid=0.
- M_COUNT=1: grant always 0; behaviour otherwise identical.

## Timing
- Request in IDLE at cycle 0 -> grant registered, in_rready high cycle 1 -> out_rvalid high cycle 2.
- Within a burst: 1 beat/cycle when out_rready stays high.
- Between bursts: one IDLE cycle (input-side bubble) per burst.
- Backpressure: out_rready low with out_rvalid high -> in_rready[grant] low same cycle (combinational from out_rvalid, out_rready); output payload stable until accepted.
- No combinational path from any in_* to any out_* other than in_rready.

## Structure
- Package axi_r_arb_pkg: state enum (IDLE, BURST), index-width helper function.
- Sub-module rr_arbiter: M_COUNT-wide request vector + last_grant -> grant index and valid; purely combinational, reused by the future AW/AR arbiters.

## Test plan
- Reset then channel 0 sends 4-beat burst, out_rready=1 -> out beats on cycles 2..5, out_rsrc=0, out_rlast only on 4th.
- Channels 1 and 3 both request from IDLE (last_grant=0) -> channel 1 burst completes entirely, then channel 3; no beat interleave.
- All four request continuously with 1-beat bursts -> grant order 0,1,2,3,0; one idle cycle between each.
- out_rready toggled 1/0 each cycle during 8-beat burst -> all 8 beats delivered in order, payload stable while stalled, no drop/duplicate.
- rst asserted mid-burst at beat 2 -> out_rvalid and in_rready low immediately; after release, channel 0 wins first.
- M_COUNT=1, DATA_WIDTH=128 build -> single channel passes bursts with 2-cycle first-beat latency.
